// File: rtl/dvi_receiver_if.sv
// Receive-side bundle: word-aligned TMDS symbols in, decoded video, coordinates and link status out.
interface dvi_receiver_if;
  logic [9:0]  tmds_r;
  logic [9:0]  tmds_g;
  logic [9:0]  tmds_b;
  logic [23:0] rgb_data;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic [9:0]  xpos;
  logic [9:0]  ypos;
  logic        line_end;
  logic        frame_end;
  logic        locked;
  logic        symbol_error;

  modport master (
    output tmds_r, tmds_g, tmds_b,
    input  rgb_data, hsync, vsync, active, xpos, ypos,
    input  line_end, frame_end, locked, symbol_error
  );

  modport slave (
    input  tmds_r, tmds_g, tmds_b,
    output rgb_data, hsync, vsync, active, xpos, ypos,
    output line_end, frame_end, locked, symbol_error
  );
endinterface

// File: rtl/dvi_receiver.sv
// TMDS to RGB receiver: decodes three symbol streams, tracks link lock and regenerates
// pixel coordinates and line/frame strobes, all one register stage behind the input.
//
// state  | meaning
// HUNT   | counting consecutive clean blanking cycles; video outputs and coordinates held at 0
// LOCKED | link valid; video, coordinates and strobes driven; mismatch errors counted per frame
module dvi_receiver #(
  parameter int unsigned LOCK_COUNT      = 16,
  parameter int unsigned ERR_LIMIT       = 8,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic          clk_pixel,
  input  logic          n_reset,
  dvi_receiver_if.slave rx
);
  localparam int unsigned LW    = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam logic        VS_ON = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

  typedef enum logic {HUNT, LOCKED} state_t;

  function automatic logic is_ctrl(input logic [9:0] sym);
    return (sym == 10'h354) || (sym == 10'h0AB) || (sym == 10'h154) || (sym == 10'h2AB);
  endfunction

  function automatic logic [1:0] ctrl_bits(input logic [9:0] sym);
    logic [1:0] c;
    case (sym)
      10'h0AB: c = 2'b01;
      10'h154: c = 2'b10;
      10'h2AB: c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] sym);
    logic [7:0] q;
    logic [7:0] d;
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  state_t          state_q, state_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [3:0]      err_cnt_q, err_cnt_d, err_inc;
  logic [23:0]     rgb_q, rgb_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d, vs_prev_q;
  logic            active_q, active_d, line_end_q, line_end_d;
  logic            frame_end_q, frame_end_d, sym_err_q, sym_err_d;
  logic [9:0]      xpos_q, xpos_d, ypos_q, ypos_d;
  logic            ctl_r, ctl_g, ctl_b, is_data, is_blank, is_err, lock_d;

  assign ctl_r    = is_ctrl(rx.tmds_r);
  assign ctl_g    = is_ctrl(rx.tmds_g);
  assign ctl_b    = is_ctrl(rx.tmds_b);
  assign is_data  = ~ctl_r & ~ctl_g & ~ctl_b;
  assign is_blank = ctl_r & ctl_g & ctl_b;
  assign is_err   = ~is_data & ~is_blank;
  assign err_inc  = (err_cnt_q == 4'hF) ? err_cnt_q : err_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    err_cnt_d   = err_cnt_q;
    rgb_d       = rgb_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;

    case (state_q)
      HUNT: begin
        lock_cnt_d = '0;
        if (is_blank) begin
          if (lock_cnt_q == LW'(LOCK_COUNT - 1)) state_d = LOCKED;
          else lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      LOCKED: if (is_err && (32'(err_inc) >= ERR_LIMIT)) state_d = HUNT;
      default: state_d = HUNT;
    endcase
    lock_d = (state_d == LOCKED);

    // Error cycles keep the previous sync levels; only clean blanking updates them.
    if (is_blank) {vsync_d, hsync_d} = ctrl_bits(rx.tmds_b);

    sym_err_d   = is_err;
    active_d    = lock_d & is_data;
    line_end_d  = lock_d & active_q & ~is_data;
    frame_end_d = lock_d & (vsync_d == VS_ON) & (vs_prev_q != VS_ON);

    if (!lock_d) rgb_d = '0;
    else if (is_data) rgb_d = {tmds_decode(rx.tmds_r), tmds_decode(rx.tmds_g), tmds_decode(rx.tmds_b)};

    if (!active_d || !active_q) xpos_d = '0;
    else if (xpos_q != '1) xpos_d = xpos_q + 10'd1;

    if (!lock_d || (state_q == HUNT) || frame_end_d) begin
      ypos_d    = '0;
      err_cnt_d = '0;
    end else begin
      if (line_end_d && (ypos_q != '1)) ypos_d = ypos_q + 10'd1;
      if (is_err) err_cnt_d = err_inc;
    end
  end

  always_ff @(posedge clk_pixel or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= HUNT;
      lock_cnt_q  <= '0;
      err_cnt_q   <= '0;
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      vs_prev_q   <= VS_ON;
      active_q    <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      sym_err_q   <= 1'b0;
      xpos_q      <= '0;
      ypos_q      <= '0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      err_cnt_q   <= err_cnt_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      vs_prev_q   <= vsync_d;
      active_q    <= active_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      sym_err_q   <= sym_err_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
    end
  end

  assign rx.rgb_data     = rgb_q;
  assign rx.hsync        = hsync_q;
  assign rx.vsync        = vsync_q;
  assign rx.active       = active_q;
  assign rx.xpos         = xpos_q;
  assign rx.ypos         = ypos_q;
  assign rx.line_end     = line_end_q;
  assign rx.frame_end    = frame_end_q;
  assign rx.locked       = (state_q == LOCKED);
  assign rx.symbol_error = sym_err_q;
endmodule
